// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit BCD seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit enables, active-low; an[0] = ones, an[1] = tens.
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  typedef enum logic {
    SelOnes = 1'b0,
    SelTens = 1'b1
  } slot_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; codes 10-15 fall through to the dash pattern.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Cascaded tens digit with sticky overflow, plus a two-slot multiplexed
// seven-segment driver with optional leading-zero blanking of the tens digit.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones_bcd,
  input  logic       carry_in,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] tens_bcd,
  output logic       ovf
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

  logic [3:0]         tens_q, tens_d;
  logic               ovf_q, ovf_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  slot_e              sel_q, sel_d;
  logic [6:0]         seg_q, seg_d;
  logic [1:0]         an_q, an_d;
  logic [3:0]         dec_in;
  logic [6:0]         dec_seg;

  // One shared decoder; the tens side sees the registered value, so a carry on
  // this edge shows up on the display one slot-cycle later.
  assign dec_in = (sel_q == SelTens) ? tens_q : ones_bcd;

  seg7_decoder u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  // Tens counter: clear beats carry; the 9->0 wrap latches overflow.
  always_comb begin
    tens_d = tens_q;
    ovf_d  = ovf_q;
    if (clr) begin
      tens_d = 4'd0;
      ovf_d  = 1'b0;
    end else if (carry_in) begin
      if (tens_q >= 4'd9) begin
        tens_d = 4'd0;
        ovf_d  = 1'b1;
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end
  end

  // Prescaler and slot select: sel flips on the last prescaler count.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    sel_d   = sel_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      sel_d   = (sel_q == SelOnes) ? SelTens : SelOnes;
    end
  end

  // Display next-state: seg and an are computed together so they always move as a pair.
  always_comb begin
    an_d  = AN_ONES;
    seg_d = dec_seg;
    if (sel_q == SelTens) begin
      if ((BLANK_LZ != 0) && (tens_q == 4'd0) && !ovf_q) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end else begin
        an_d  = AN_TENS;
        seg_d = dec_seg;
      end
    end
  end

  // State and output registers with asynchronous reset to a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= 4'd0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      sel_q   <= SelOnes;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      tens_q  <= tens_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign tens_bcd = tens_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with a small reference model and scoreboard.
module tb_bcd_display_scanner;

  localparam int SD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] ones_bcd;
  logic       carry_in;
  logic       clr;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] tens_bcd;
  logic       ovf;

  bcd_display_scanner #(
    .SCAN_DIV (SD),
    .BLANK_LZ (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ones_bcd (ones_bcd),
    .carry_in (carry_in),
    .clr      (clr),
    .seg      (seg),
    .an       (an),
    .tens_bcd (tens_bcd),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] tens;
    logic       ovf;
  } exp_t;

  dec_vec_t dec_tab [16];
  exp_t     sb_q [$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0] m_tens;
  logic       m_ovf;
  int         m_presc;
  logic       m_sel;
  logic [1:0] last_an;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tens  = 4'd0;
    m_ovf   = 1'b0;
    m_presc = 0;
    m_sel   = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
  task automatic step(input logic [3:0] o, input logic c, input logic k);
    exp_t e;
    exp_t got;
    @(negedge clk);
    ones_bcd = o;
    carry_in = c;
    clr      = k;
    if (!m_sel) begin
      e.an  = 2'b10;
      e.seg = dec_tab[o].seg;
    end else if (m_tens == 4'd0 && !m_ovf) begin
      e.an  = 2'b11;
      e.seg = 7'b1111111;
    end else begin
      e.an  = 2'b01;
      e.seg = dec_tab[m_tens].seg;
    end
    if (k) begin
      m_tens = 4'd0;
      m_ovf  = 1'b0;
    end else if (c) begin
      if (m_tens == 4'd9) begin
        m_tens = 4'd0;
        m_ovf  = 1'b1;
      end else begin
        m_tens = m_tens + 4'd1;
      end
    end
    e.tens = m_tens;
    e.ovf  = m_ovf;
    if (m_presc == SD - 1) begin
      m_presc = 0;
      m_sel   = ~m_sel;
    end else begin
      m_presc++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("sb_seg", {25'd0, seg}, {25'd0, got.seg});
    check("sb_an", {30'd0, an}, {30'd0, got.an});
    check("sb_tens", {28'd0, tens_bcd}, {28'd0, got.tens});
    check("sb_ovf", {31'd0, ovf}, {31'd0, got.ovf});
    last_an = got.an;
  endtask

  // Step with steady inputs until the wanted slot is showing (bounded).
  task automatic goto_slot(input logic [1:0] want, input logic [3:0] o, input string name);
    for (int i = 0; i < 2 * SD + 1; i++) begin
      step(o, 1'b0, 1'b0);
      if (last_an == want) break;
    end
    check(name, {30'd0, an}, {30'd0, want});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_tab[0]  = '{4'd0,  7'b1000000};
    dec_tab[1]  = '{4'd1,  7'b1111001};
    dec_tab[2]  = '{4'd2,  7'b0100100};
    dec_tab[3]  = '{4'd3,  7'b0110000};
    dec_tab[4]  = '{4'd4,  7'b0011001};
    dec_tab[5]  = '{4'd5,  7'b0010010};
    dec_tab[6]  = '{4'd6,  7'b0000010};
    dec_tab[7]  = '{4'd7,  7'b1111000};
    dec_tab[8]  = '{4'd8,  7'b0000000};
    dec_tab[9]  = '{4'd9,  7'b0010000};
    dec_tab[10] = '{4'd10, 7'b0111111};
    dec_tab[11] = '{4'd11, 7'b0111111};
    dec_tab[12] = '{4'd12, 7'b0111111};
    dec_tab[13] = '{4'd13, 7'b0111111};
    dec_tab[14] = '{4'd14, 7'b0111111};
    dec_tab[15] = '{4'd15, 7'b0111111};

    rst_n    = 1'b0;
    ones_bcd = 4'd7;
    carry_in = 1'b0;
    clr      = 1'b0;
    last_an  = 2'b11;
    model_reset();

    // Reset state
    #12;
    check("rst_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    check("rst_an", {30'd0, an}, {30'd0, 2'b11});
    check("rst_tens", {28'd0, tens_bcd}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    // First edge shows the ones digit, then the blanked tens slot after SD cycles
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'd7, 1'b0, 1'b0);
    check("first_an", {30'd0, an}, {30'd0, 2'b10});
    check("first_seg", {25'd0, seg}, {25'd0, 7'b1111000});
    for (int i = 0; i < SD; i++) step(4'd7, 1'b0, 1'b0);
    check("blank_an", {30'd0, an}, {30'd0, 2'b11});
    check("blank_seg", {25'd0, seg}, {25'd0, 7'b1111111});

    // Decode table through the ones slot
    for (int i = 0; i < 16; i++) begin
      goto_slot(2'b10, dec_tab[i].code, "dec_slot");
      check("dec_seg", {25'd0, seg}, {25'd0, dec_tab[i].seg});
    end

    // Three single-cycle carries
    for (int i = 0; i < 3; i++) begin
      step(4'd7, 1'b1, 1'b0);
      step(4'd7, 1'b0, 1'b0);
    end
    check("tens_3", {28'd0, tens_bcd}, 32'd3);
    goto_slot(2'b01, 4'd7, "tens3_slot");
    check("tens3_seg", {25'd0, seg}, {25'd0, 7'b0110000});

    // Level-sampled carry held three cycles adds three
    for (int i = 0; i < 3; i++) step(4'd7, 1'b1, 1'b0);
    check("held_carry", {28'd0, tens_bcd}, 32'd6);
    step(4'd7, 1'b0, 1'b1);
    check("clr_tens", {28'd0, tens_bcd}, 32'd0);

    // Ten carries wrap to zero and set overflow; tens zero no longer blanked
    for (int i = 0; i < 10; i++) begin
      step(4'd7, 1'b1, 1'b0);
      step(4'd7, 1'b0, 1'b0);
    end
    check("wrap_tens", {28'd0, tens_bcd}, 32'd0);
    check("wrap_ovf", {31'd0, ovf}, 32'd1);
    goto_slot(2'b01, 4'd7, "ovf_slot");
    check("ovf_seg", {25'd0, seg}, {25'd0, 7'b1000000});

    // clr and carry together: clr wins
    step(4'd7, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'd7, 1'b1, 1'b0);
    check("tens_5", {28'd0, tens_bcd}, 32'd5);
    step(4'd7, 1'b1, 1'b1);
    check("clr_win_tens", {28'd0, tens_bcd}, 32'd0);
    check("clr_win_ovf", {31'd0, ovf}, 32'd0);

    // Invalid code on the ones digit
    goto_slot(2'b10, 4'd12, "dash_slot");
    check("dash_seg", {25'd0, seg}, {25'd0, 7'b0111111});

    // Asynchronous reset mid-slot with tens=6, presc=2
    for (int i = 0; i < 6; i++) step(4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 2 * SD; i++) begin
      if (m_presc == 2) break;
      step(4'd7, 1'b0, 1'b0);
    end
    check("pre_rst_presc", 32'(dut.presc_q), 32'd2);
    check("pre_rst_tens", {28'd0, tens_bcd}, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg", {25'd0, seg}, {25'd0, 7'b1111111});
    check("arst_an", {30'd0, an}, {30'd0, 2'b11});
    check("arst_tens", {28'd0, tens_bcd}, 32'd0);
    check("arst_ovf", {31'd0, ovf}, 32'd0);
    check("arst_presc", 32'(dut.presc_q), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'd3, 1'b0, 1'b0);
    check("rerun_seg", {25'd0, seg}, {25'd0, 7'b0110000});
    for (int i = 0; i < 2 * SD; i++) step(4'd3, 1'b0, 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream consumer of the decade counter: takes its 4-bit BCD ones digit and carry, keeps the cascaded tens digit, and drives a time-multiplexed two-digit, active-low seven-segment display. Sits between the counter and the board display pins. Handles the tens carry chain, overflow, leading-zero blanking and invalid-code indication.

## Interface
- SCAN_DIV, 100000: clk cycles per digit slot (1 kHz at 100 MHz); legal range ≥ 1; benches use 4.
- BLANK_LZ, 1: 1 blanks the tens digit while tens==0 and ovf==0.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ones_bcd  in  4  ones digit from the counter, bit 3 = MSB (counter output a = bit 3, d = bit 0).
- carry_in  in  1  counter carry (z); high during the cycle in which the ones digit wraps 9→0.
- clr  in  1  synchronous clear of tens and ovf.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  out  2  digit enables, active-low, registered; an[0] = ones, an[1] = tens.
- tens_bcd  out  4  current tens digit, registered.
- ovf  out  1  sticky overflow, registered.

## Operation
- Tens register updates on every rising clk edge with this priority: clr=1 → tens=0, ovf=0; else carry_in=1 → tens+1. The 9→0 wrap sets ovf=1. Otherwise hold.
- carry_in is level-sampled each cycle, not edge-detected. A carry held high for N cycles adds N.
- clr and carry_in high in the same cycle: clr wins and the carry is lost.
- Prescaler presc counts 0..SCAN_DIV-1 and wraps. When presc==SCAN_DIV-1, sel toggles (0 = ones slot, 1 = tens slot).
- Display register, every cycle:
  - sel=0: an=2'b10, seg=decode(ones_bcd).
  - sel=1: an=2'b01, seg=decode(tens).
  - sel=1 with BLANK_LZ=1, tens==0 and ovf==0: an=2'b11, seg=7'b1111111.
- Decode table (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 = 0111111 (dash, g only).
- Tens digit display uses the tens value before any same-edge update; this is the registered value.

## Timing
- Reset (async, immediate): tens=0, ovf=0, presc=0, sel=0, an=2'b11, seg=7'b1111111.
- Latency:
  - ones_bcd → seg: 1 cycle.
  - carry_in → tens_bcd: 1 cycle.
  - carry_in → tens digit on seg: 2 cycles, while in the tens slot.
- First rising edge after rst_n deasserts: an=2'b10, seg=decode(ones_bcd).
- Slot length: exactly SCAN_DIV cycles per digit, period 2·SCAN_DIV. SCAN_DIV=1 alternates every cycle.
- Reset asserted mid-scan or mid-count: all state returns to reset values asynchronously; no partial update survives.
- seg and an always change on the same edge; no cycle shows a new an with an old seg.

## Structure
- Package bcd_disp_pkg holds:
  - the ten digit patterns plus SEG_DASH and SEG_BLANK constants;
  - AN_ONES=2'b10, AN_TENS=2'b01, AN_OFF=2'b11.
- One sub-module, seg7_decoder: purely combinational 4-bit → 7-bit using the package constants, with dash for codes above 9. Top-level holds the tens counter, prescaler, sel and output registers.
- Prescaler width: $clog2(SCAN_DIV), minimum 1 bit.

## Test plan
- Reset then release with ones_bcd=4'd7, SCAN_DIV=4 → first edge an=10, seg=1111000. After 4 cycles an=11, seg=1111111 (blanked tens).
- Pulse carry_in for one cycle, three times → tens_bcd=3. In the tens slot an=01, seg=0110000.
- Ten single-cycle carries → tens_bcd=0, ovf=1. Tens slot now shows an=01, seg=1000000 (no blanking).
- clr=1 and carry_in=1 in the same cycle with tens=5 → next edge tens=0, ovf=0.
- ones_bcd=4'd12 → ones slot seg=0111111.
- Assert rst_n low mid-slot with tens=6, presc=2 → seg, an, tens, ovf and presc go to reset values without waiting for a clk edge.
